// File: rtl/ng_seq_gen_pkg.sv
// Shared definitions for the AGC sequence generator: branch-test indices and
// the JK excitation terms of both branch registers.
package ng_seq_pkg;

  localparam int TST_SGN  = 0;
  localparam int TST_SGN2 = 1;
  localparam int TST_OV   = 2;
  localparam int TST_MZ   = 3;
  localparam int TST_PZ   = 4;
  localparam int TST_W    = 5;

  // Returns {J, K}; sel_br2 picks the BR2 equations, otherwise BR1.
  function automatic logic [1:0] br_jk(
    input logic             sel_br2,
    input logic [TST_W-1:0] tst,
    input logic             sign,
    input logic             over,
    input logic             mz,
    input logic             pz
  );
    logic j_s;
    logic k_s;
    if (sel_br2) begin
      j_s = (tst[TST_SGN2] & sign) | (tst[TST_OV] & ~sign & over)
          | (tst[TST_MZ] & mz) | (tst[TST_PZ] & pz);
      k_s = (tst[TST_SGN2] & ~sign) | (tst[TST_OV] & sign) | (tst[TST_OV] & ~over)
          | (tst[TST_MZ] & ~mz) | (tst[TST_PZ] & ~pz);
    end else begin
      j_s = (tst[TST_SGN] & sign) | (tst[TST_OV] & sign & ~over);
      k_s = (tst[TST_SGN] & ~sign) | (tst[TST_OV] & ~sign) | (tst[TST_OV] & over);
    end
    return {j_s, k_s};
  endfunction

endpackage

// File: rtl/ng_seq_gen_if.sv
// Control-pulse / write-bus interface between the pulse decoder (master)
// and the sequence generator (slave).
interface ng_seq_gen_if #(
  parameter int DATA_W = 16,
  parameter int SQ_W   = 4,
  parameter int STG_W  = 2
);
  logic [DATA_W-1:0] WRITE_BUS;
  logic              WSQ_N, NISQ_N, CLISQ_N, EXT_N;
  logic [STG_W-1:0]  ST_N;
  logic              CLSTA_N, CLSTB_N, SETSTB_N, WSTB_N;
  logic              TSGN_N, TSGN2_N, TOV_N, TMZ_N, TPZ_N;
  logic              CTR_N, CLCTR_N;
  logic              SNI;
  logic [STG_W-1:0]  STB;
  logic              BR1, BR2;
  logic [SQ_W-1:0]   SQ;
  logic              SQEXT, LOOP_N_O, LOOP_DONE;

  modport master (
    output WRITE_BUS, WSQ_N, NISQ_N, CLISQ_N, EXT_N, ST_N,
           CLSTA_N, CLSTB_N, SETSTB_N, WSTB_N,
           TSGN_N, TSGN2_N, TOV_N, TMZ_N, TPZ_N, CTR_N, CLCTR_N,
    input  SNI, STB, BR1, BR2, SQ, SQEXT, LOOP_N_O, LOOP_DONE
  );

  modport slave (
    input  WRITE_BUS, WSQ_N, NISQ_N, CLISQ_N, EXT_N, ST_N,
           CLSTA_N, CLSTB_N, SETSTB_N, WSTB_N,
           TSGN_N, TSGN2_N, TOV_N, TMZ_N, TPZ_N, CTR_N, CLCTR_N,
    output SNI, STB, BR1, BR2, SQ, SQEXT, LOOP_N_O, LOOP_DONE
  );
endinterface

// File: rtl/ng_seq_gen_jkbr.sv
// JK branch flip-flop: J=K=1 toggles, J=K=0 holds.
module ng_seq_jkbr (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);
  // JK state update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= (~q & j) | (q & ~k);
  end
endmodule

// File: rtl/ng_seq_gen.sv
// AGC sequence generator: SQ/EXTEND, stage STA->STB, branch registers and
// loop counter, all updated on the rising edge of CLK2.
module ng_seq_gen
  import ng_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SQ_W   = 4,
  parameter int STG_W  = 2,
  parameter int CNT_W  = 4,
  parameter int LOOP_N = 6
) (
  input logic         CLK2,
  input logic         GENRST,
  ng_seq_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] LOOP_TC = LOOP_N[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STG_W-1:0] STB_ONE = {{(STG_W-1){1'b0}}, 1'b1};

  logic              sni_r, sqext_r, ext_pend_r, hit_r, done_r;
  logic [SQ_W-1:0]   sq_r;
  logic [STG_W-1:0]  sta_r, stb_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sign_s, over_s, mz_s, pz_s, at_tc_s;
  logic [TST_W-1:0]  tst_s;
  logic [1:0]        jk1_s, jk2_s;

  // Write-bus decode and branch excitation terms
  always_comb begin
    sign_s = bus.WRITE_BUS[DATA_W-1];
    over_s = bus.WRITE_BUS[DATA_W-2];
    mz_s   = &bus.WRITE_BUS;
    pz_s   = ~|bus.WRITE_BUS;
    tst_s           = '0;
    tst_s[TST_SGN]  = ~bus.TSGN_N;
    tst_s[TST_SGN2] = ~bus.TSGN2_N;
    tst_s[TST_OV]   = ~bus.TOV_N;
    tst_s[TST_MZ]   = ~bus.TMZ_N;
    tst_s[TST_PZ]   = ~bus.TPZ_N;
    jk1_s = br_jk(1'b0, tst_s, sign_s, over_s, mz_s, pz_s);
    jk2_s = br_jk(1'b1, tst_s, sign_s, over_s, mz_s, pz_s);
  end

  ng_seq_jkbr u_br1 (.clk(CLK2), .rst_n(GENRST), .j(jk1_s[1]), .k(jk1_s[0]), .q(bus.BR1));
  ng_seq_jkbr u_br2 (.clk(CLK2), .rst_n(GENRST), .j(jk2_s[1]), .k(jk2_s[0]), .q(bus.BR2));

  // SNI: clear wins over set
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST)           sni_r <= 1'b0;
    else if (!bus.CLISQ_N) sni_r <= 1'b0;
    else if (!bus.NISQ_N)  sni_r <= 1'b1;
    else                   sni_r <= sni_r;
  end

  // SQ load; an EXTEND seen in the same cycle as WSQ still qualifies it
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      sq_r       <= '0;
      sqext_r    <= 1'b0;
      ext_pend_r <= 1'b0;
    end else if (!bus.WSQ_N) begin
      sq_r       <= bus.WRITE_BUS[DATA_W-1 -: SQ_W];
      sqext_r    <= ext_pend_r | ~bus.EXT_N;
      ext_pend_r <= 1'b0;
    end else if (!bus.EXT_N) begin
      ext_pend_r <= 1'b1;
    end
  end

  // Stage registers; WSTB transfers the pre-clear STA value
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      sta_r <= '0;
      stb_r <= '0;
    end else begin
      if (!bus.CLSTA_N) sta_r <= '0;
      else              sta_r <= sta_r | ~bus.ST_N;
      if (!bus.CLSTB_N)       stb_r <= '0;
      else if (!bus.SETSTB_N) stb_r <= STB_ONE;
      else if (!bus.WSTB_N)   stb_r <= sta_r;
      else                    stb_r <= stb_r;
    end
  end

  assign at_tc_s = (cnt_r == LOOP_TC);

  // Loop counter; done fires once, the edge after the counter enters LOOP_N
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      cnt_r  <= '0;
      hit_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (!bus.CLCTR_N)   cnt_r <= '0;
      else if (!bus.CTR_N) cnt_r <= cnt_r + CNT_ONE;
      else                cnt_r <= cnt_r;
      hit_r  <= at_tc_s;
      done_r <= at_tc_s & ~hit_r;
    end
  end

  assign bus.SNI       = sni_r;
  assign bus.SQ        = sq_r;
  assign bus.SQEXT     = sqext_r;
  assign bus.STB       = stb_r;
  assign bus.LOOP_N_O  = ~at_tc_s;
  assign bus.LOOP_DONE = done_r;
endmodule

// File: tb/tb_ng_seq_gen.sv
// Directed, table-driven bench for ng_seq_gen with hand-written loop and
// reset sequences.
module tb_ng_seq_gen;
  localparam int DATA_W = 16;
  localparam int SQ_W   = 4;
  localparam int STG_W  = 2;
  localparam int CNT_W  = 4;
  localparam int LOOP_N = 6;

  localparam int P_WSQ = 0,  P_NISQ = 1,  P_CLISQ = 2,  P_EXT = 3,  P_ST0 = 4,  P_ST1 = 5;
  localparam int P_CLSTA = 6, P_CLSTB = 7, P_SETSTB = 8, P_WSTB = 9, P_TSGN = 10;
  localparam int P_TSGN2 = 11, P_TOV = 12, P_TMZ = 13, P_TPZ = 14, P_CTR = 15, P_CLCTR = 16;
  localparam int NP = 17;
  localparam int NV = 26;

  typedef struct {
    logic [NP-1:0] p;
    logic [15:0]   wb;
    logic          sni;
    logic [1:0]    stb;
    logic          br1;
    logic          br2;
    logic [3:0]    sq;
    logic          sqext;
  } vec_t;

  logic CLK2   = 1'b0;
  logic GENRST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tv[NV];

  ng_seq_gen_if #(.DATA_W(DATA_W), .SQ_W(SQ_W), .STG_W(STG_W)) bus ();

  ng_seq_gen #(.DATA_W(DATA_W), .SQ_W(SQ_W), .STG_W(STG_W), .CNT_W(CNT_W), .LOOP_N(LOOP_N))
    dut (.CLK2(CLK2), .GENRST(GENRST), .bus(bus));

  always #5 CLK2 = ~CLK2;

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running, required finish");
    $fatal(1);
  end

  function automatic logic [NP-1:0] pb(input int i);
    logic [NP-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [NP-1:0] p, input logic [15:0] wb, input logic sni,
                              input logic [1:0] stb, input logic br1, input logic br2,
                              input logic [3:0] sq, input logic sqext);
    vec_t v;
    v.p = p; v.wb = wb; v.sni = sni; v.stb = stb;
    v.br1 = br1; v.br2 = br2; v.sq = sq; v.sqext = sqext;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [NP-1:0] p, input logic [15:0] wb);
    bus.WRITE_BUS = wb;
    bus.WSQ_N     = ~p[P_WSQ];
    bus.NISQ_N    = ~p[P_NISQ];
    bus.CLISQ_N   = ~p[P_CLISQ];
    bus.EXT_N     = ~p[P_EXT];
    bus.ST_N      = ~{p[P_ST1], p[P_ST0]};
    bus.CLSTA_N   = ~p[P_CLSTA];
    bus.CLSTB_N   = ~p[P_CLSTB];
    bus.SETSTB_N  = ~p[P_SETSTB];
    bus.WSTB_N    = ~p[P_WSTB];
    bus.TSGN_N    = ~p[P_TSGN];
    bus.TSGN2_N   = ~p[P_TSGN2];
    bus.TOV_N     = ~p[P_TOV];
    bus.TMZ_N     = ~p[P_TMZ];
    bus.TPZ_N     = ~p[P_TPZ];
    bus.CTR_N     = ~p[P_CTR];
    bus.CLCTR_N   = ~p[P_CLCTR];
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later
  task automatic step(input logic [NP-1:0] p, input logic [15:0] wb);
    @(negedge CLK2);
    drive(p, wb);
    @(posedge CLK2);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic sni, input logic [1:0] stb, input logic br1,
                         input logic br2, input logic [3:0] sq, input logic sqext,
                         input logic lno, input logic done);
    chk({tag, ".SNI"},       32'(bus.SNI),       32'(sni));
    chk({tag, ".STB"},       32'(bus.STB),       32'(stb));
    chk({tag, ".BR1"},       32'(bus.BR1),       32'(br1));
    chk({tag, ".BR2"},       32'(bus.BR2),       32'(br2));
    chk({tag, ".SQ"},        32'(bus.SQ),        32'(sq));
    chk({tag, ".SQEXT"},     32'(bus.SQEXT),     32'(sqext));
    chk({tag, ".LOOP_N_O"},  32'(bus.LOOP_N_O),  32'(lno));
    chk({tag, ".LOOP_DONE"}, 32'(bus.LOOP_DONE), 32'(done));
  endtask

  initial begin
    logic [NP-1:0] zero_p;
    zero_p = '0;

    //               pulses                           wb        sni stb   br1 br2 sq     sqext
    tv[0]  = mk(pb(P_EXT),                          16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    tv[1]  = mk(pb(P_WSQ),                          16'h5123, 1'b0, 2'd0, 1'b0, 1'b0, 4'h5, 1'b1);
    tv[2]  = mk(pb(P_WSQ),                          16'hA000, 1'b0, 2'd0, 1'b0, 1'b0, 4'hA, 1'b0);
    tv[3]  = mk(pb(P_WSQ) | pb(P_EXT),              16'h3000, 1'b0, 2'd0, 1'b0, 1'b0, 4'h3, 1'b1);
    tv[4]  = mk(pb(P_TSGN),                         16'h8000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[5]  = mk(pb(P_TSGN),                         16'h0001, 1'b0, 2'd0, 1'b0, 1'b0, 4'h3, 1'b1);
    tv[6]  = mk(pb(P_TPZ),                          16'h0000, 1'b0, 2'd0, 1'b0, 1'b1, 4'h3, 1'b1);
    tv[7]  = mk(pb(P_TMZ),                          16'hFFFF, 1'b0, 2'd0, 1'b0, 1'b1, 4'h3, 1'b1);
    tv[8]  = mk(pb(P_TMZ),                          16'h0001, 1'b0, 2'd0, 1'b0, 1'b0, 4'h3, 1'b1);
    tv[9]  = mk(pb(P_TOV),                          16'h4000, 1'b0, 2'd0, 1'b0, 1'b1, 4'h3, 1'b1);
    tv[10] = mk(pb(P_TOV),                          16'hC000, 1'b0, 2'd0, 1'b0, 1'b0, 4'h3, 1'b1);
    tv[11] = mk(pb(P_TOV),                          16'h8000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[12] = mk(pb(P_TSGN) | pb(P_TOV),             16'hC000, 1'b0, 2'd0, 1'b0, 1'b0, 4'h3, 1'b1);
    tv[13] = mk(pb(P_TSGN) | pb(P_TOV),             16'hC000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[14] = mk(pb(P_NISQ),                         16'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[15] = mk(zero_p,                             16'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[16] = mk(pb(P_NISQ) | pb(P_CLISQ),           16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[17] = mk(pb(P_ST0),                          16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[18] = mk(pb(P_ST1),                          16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[19] = mk(pb(P_WSTB) | pb(P_CLSTA),           16'h0000, 1'b0, 2'd3, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[20] = mk(pb(P_WSTB),                         16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[21] = mk(pb(P_SETSTB) | pb(P_WSTB),          16'h0000, 1'b0, 2'd1, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[22] = mk(pb(P_CLSTB) | pb(P_SETSTB),         16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[23] = mk(pb(P_ST1),                          16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[24] = mk(pb(P_WSTB),                         16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 4'h3, 1'b1);
    tv[25] = mk(pb(P_CLSTB) | pb(P_WSTB),           16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'h3, 1'b1);

    // Reset held with every pulse active
    drive({NP{1'b1}}, 16'hFFFF);
    repeat (3) @(posedge CLK2);
    #1;
    chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK2);
    drive(zero_p, 16'h0000);
    GENRST = 1'b1;
    for (int i = 0; i < 3; i++) step(zero_p, 16'h0000);
    chk_all("post_reset", 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(tv[i].p, tv[i].wb);
      chk_all($sformatf("vec%0d", i), tv[i].sni, tv[i].stb, tv[i].br1, tv[i].br2,
              tv[i].sq, tv[i].sqext, 1'b1, 1'b0);
    end

    // Loop counter reaches LOOP_N, strobes once, then holds
    for (int i = 1; i <= LOOP_N; i++) begin
      step(pb(P_CTR), 16'h0000);
      chk($sformatf("lap1_lno_%0d", i), 32'(bus.LOOP_N_O), (i == LOOP_N) ? 32'd0 : 32'd1);
      chk($sformatf("lap1_done_%0d", i), 32'(bus.LOOP_DONE), 32'd0);
    end
    step(zero_p, 16'h0000);
    chk("done_pulse", 32'(bus.LOOP_DONE), 32'd1);
    chk("hold_lno", 32'(bus.LOOP_N_O), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(zero_p, 16'h0000);
      chk($sformatf("done_hold_%0d", i), 32'(bus.LOOP_DONE), 32'd0);
    end

    // 10 more pulses wrap 6 -> 0, then 6 more reach LOOP_N again
    for (int i = 0; i < 10; i++) step(pb(P_CTR), 16'h0000);
    chk("wrap_lno", 32'(bus.LOOP_N_O), 32'd1);
    for (int i = 1; i <= LOOP_N; i++) begin
      step(pb(P_CTR), 16'h0000);
      chk($sformatf("lap2_lno_%0d", i), 32'(bus.LOOP_N_O), (i == LOOP_N) ? 32'd0 : 32'd1);
    end
    step(zero_p, 16'h0000);
    chk("lap2_done", 32'(bus.LOOP_DONE), 32'd1);

    // Clear beats increment
    step(pb(P_CLCTR) | pb(P_CTR), 16'h0000);
    chk("clr_lno", 32'(bus.LOOP_N_O), 32'd1);
    for (int i = 1; i <= LOOP_N; i++) begin
      step(pb(P_CTR), 16'h0000);
      chk($sformatf("lap3_lno_%0d", i), 32'(bus.LOOP_N_O), (i == LOOP_N) ? 32'd0 : 32'd1);
    end

    // Asynchronous reset mid-count (counter = 4, SNI = 1)
    step(pb(P_CLCTR), 16'h0000);
    for (int i = 0; i < 4; i++) step(pb(P_CTR), 16'h0000);
    step(pb(P_NISQ), 16'h0000);
    chk("pre_rst_sni", 32'(bus.SNI), 32'd1);
    @(negedge CLK2);
    drive(zero_p, 16'h0000);
    #2;
    GENRST = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK2);
    GENRST = 1'b1;
    for (int i = 1; i <= LOOP_N; i++) begin
      step(pb(P_CTR), 16'h0000);
      chk($sformatf("post_rst_lno_%0d", i), 32'(bus.LOOP_N_O), (i == LOOP_N) ? 32'd0 : 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ng_seq_gen.md
Name: ng_seq_gen

Overview:
- Parametrised sequence generator for the AGC control path, sitting between the control-pulse decoder (active-low pulses) and the time-pulse/CROM address logic.
- Holds the instruction (SQ) register with an EXTEND qualifier, a two-level stage register (STA→STB) of configurable width, and two JK branch registers with an added plus-zero test.
- Holds a loop counter with a parametrised terminal count and a one-cycle done strobe.
- Drives the microinstruction selection fields for the next cycle.

Parameters:
- DATA_W, 16, write-bus width (sign = bit DATA_W-1, overflow = bit DATA_W-2).
- SQ_W, 4, opcode bits taken from WRITE_BUS[DATA_W-1 -: SQ_W].
- STG_W, 2, stage register width.
- CNT_W, 4, loop counter width.
- LOOP_N, 6, terminal loop count; must be < 2^CNT_W.

Ports:
- CLK2  in  1  system clock; all state updates on rising edge.
- GENRST  in  1  asynchronous active-low reset.
- WRITE_BUS  in  DATA_W  write bus.
- WSQ_N, NISQ_N, CLISQ_N, EXT_N  in  1 each  load SQ / set SNI / clear SNI / set EXTEND.
- ST_N  in  STG_W  per-bit stage set pulses into STA.
- CLSTA_N, CLSTB_N, SETSTB_N, WSTB_N  in  1 each  stage clear/set/transfer.
- TSGN_N, TSGN2_N, TOV_N, TMZ_N, TPZ_N  in  1 each  branch tests.
- CTR_N, CLCTR_N  in  1 each  loop increment / clear.
- SNI  out  1  select next instruction.
- STB  out  STG_W  stage B.
- BR1, BR2  out  1 each  branch registers.
- SQ  out  SQ_W  instruction register.
- SQEXT  out  1  extracode qualifier captured with SQ.
- LOOP_N_O  out  1  active-low, 0 while counter == LOOP_N.
- LOOP_DONE  out  1  one-cycle high pulse on counter reaching LOOP_N.

Behaviour:
- Reset: GENRST low asynchronously clears all state; every output 0 except LOOP_N_O = 1 (counter 0 ≠ LOOP_N).
- All inputs are sampled on the rising edge of CLK2. Outputs are registered and reflect the edge that updated them, giving one-cycle latency. No negedge output stage.
- SNI: CLISQ_N low → 0. Else NISQ_N low → 1. Else hold. Clear wins over set.
- EXTEND latch:
  - EXT_N low sets a pending bit.
  - On WSQ_N low: SQ ← WRITE_BUS opcode field, SQEXT ← pending (or EXT_N low in the same cycle), pending ← 0.
  - Without WSQ_N, SQ and SQEXT hold.
- Branch decode: MZ = all ones; PZ = all zeros; SIGN; OVER.
- BR1 JK terms:
  - J1 = (!TSGN_N & SIGN) | (!TOV_N & SIGN & !OVER).
  - K1 = (!TSGN_N & !SIGN) | (!TOV_N & !SIGN) | (!TOV_N & OVER).
- BR2 JK terms:
  - J2 = (!TSGN2_N & SIGN) | (!TOV_N & !SIGN & OVER) | (!TMZ_N & MZ) | (!TPZ_N & PZ).
  - K2 = (!TSGN2_N & !SIGN) | (!TOV_N & SIGN) | (!TOV_N & !OVER) | (!TMZ_N & !MZ) | (!TPZ_N & !PZ).
- BR update: BR ← (~BR & J) | (BR & ~K). J = K = 1 toggles; J = K = 0 holds.
- STA: CLSTA_N low → 0 (dominates). Else STA[i] ← 1 for each ST_N[i] low; unset bits hold (bits only accumulate).
- STB priority: CLSTB_N > SETSTB_N (load 1) > WSTB_N (STB ← STA as of the previous edge) > hold. STA clear and STB transfer in the same cycle: STB gets the pre-clear STA value.
- Loop counter: CLCTR_N low → 0 (beats CTR_N). Else CTR_N low → +1 modulo 2^CNT_W (wraps; no saturation).
  - LOOP_N_O is combinational from the counter register.
  - LOOP_DONE is registered; high for one cycle the edge after the counter transitions into LOOP_N. Not re-asserted while holding.
- Reset asserted mid-operation aborts immediately. Release is synchronised externally.

Decomposition:
- Shared package ng_seq_pkg holds:
  - the control-pulse index constants;
  - the branch J/K functions as functions of (tests, SIGN, OVER, MZ, PZ).
- One sub-module, ng_seq_jkbr, is natural: a JK branch flip-flop instantiated twice.

Test Plan:
- Reset: hold GENRST low, drive all pulses active → every output 0, LOOP_N_O = 1; release, idle 3 cycles → unchanged.
- EXT_N pulse, then WSQ_N with WRITE_BUS = 16'h5xxx → SQ = 4'h5, SQEXT = 1. Next WSQ_N with 16'hA000, no EXT → SQ = 4'hA, SQEXT = 0.
- Branch tests:
  - TSGN_N with WRITE_BUS = 16'h8000 → BR1 = 1; then TSGN_N with 16'h0001 → BR1 = 0.
  - TPZ_N with 16'h0000 → BR2 = 1; TMZ_N with 16'hFFFF → BR2 stays 1; TMZ_N with 16'h0001 → BR2 = 0.
- Stages: ST_N = 2'b10 then ST_N = 2'b01 → STA = 3. WSTB_N with CLSTA_N in the same cycle → STB = 3, STA = 0. SETSTB_N with WSTB_N → STB = 1.
- Loop counter: 6 CTR_N pulses → LOOP_N_O = 0, LOOP_DONE high exactly 1 cycle. 10 more pulses → wraps to 0. CLCTR_N with CTR_N → 0.
- SNI: NISQ_N → SNI = 1. NISQ_N with CLISQ_N → SNI = 0. Assert GENRST mid-count (counter = 4) → counter 0, SNI 0 immediately.
